// File: rtl/slt_share_arbiter_pkg.sv
// Shared types and defaults for the shared less-than comparator arbiter.
package slt_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ID_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/slt_share_arbiter_if.sv
// Request/response bundle between the requesters and the comparator arbiter.
interface slt_share_arbiter_if
  import slt_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = DEF_ID_W
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_signed;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_result;

  modport master (
    output req_valid, req_signed, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result
  );

endinterface

// File: rtl/slt_share_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request strictly after ptr, with wrap-around.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // Offsets are scanned farthest-first so the nearest requester after ptr
  // is the last writer and therefore wins.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, so no
    // path leaves a value unassigned and no latch is inferred.
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (j == (int'(ptr) + off) % NUM_REQ)) begin
          grant    = '0;
          grant[j] = 1'b1;
          idx      = ID_W'(j);
          any      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/slt_share_arbiter.sv
// Round-robin owner of one subtract-based less-than comparator shared by
// NUM_REQ requesters; one op in flight, response tagged with requester ID.
module slt_share_arbiter
  import slt_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                clk,
  input  logic                reset,
  slt_share_arbiter_if.slave  bus,
  output logic                busy
);

  state_t               state, state_n;
  logic [ID_W-1:0]      ptr, pick_idx, op_id, rsp_id_q;
  logic [NUM_REQ-1:0]   pick_grant, ready_c;
  logic                 pick_any, accept;
  logic [WIDTH-1:0]     sel_a, sel_b, op_a, op_b, rsp_result_q;
  logic                 sel_signed, op_signed, rsp_valid_q;
  logic [WIDTH:0]       diff;
  logic                 ult, ovf, slt, lt;

  rr_priority_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    sel_a      = '0;
    sel_b      = '0;
    sel_signed = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (pick_grant[j]) begin
        sel_a      = bus.req_a[j*WIDTH +: WIDTH];
        sel_b      = bus.req_b[j*WIDTH +: WIDTH];
        sel_signed = bus.req_signed[j];
      end
    end
  end

  // Reset also masks the grant so req_ready is zero while reset is held.
  assign accept = (state == ST_IDLE) && pick_any && !reset;

  always_comb begin
    state_n = state;
    ready_c = '0;
    case (state)
      ST_IDLE: if (accept) begin
        ready_c = pick_grant;
        state_n = ST_EXEC;
      end
      ST_EXEC: state_n = ST_RESP;
      ST_RESP: if (bus.rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // a - b as a + ~b + 1; carry-out clear means a borrow, i.e. a < b unsigned.
  assign diff = {1'b0, op_a} + {1'b0, ~op_b} + (WIDTH+1)'(1);
  assign ult  = ~diff[WIDTH];
  assign ovf  = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
  assign slt  = diff[WIDTH-1] ^ ovf;
  assign lt   = op_signed ? slt : ult;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr          <= ID_W'(NUM_REQ - 1);
      // NOTE: operand latches are reset too; they are a handful of flops,
      // not a memory array, and a known value keeps the comparator quiet.
      op_a         <= '0;
      op_b         <= '0;
      op_signed    <= 1'b0;
      op_id        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      if (accept) begin
        op_a      <= sel_a;
        op_b      <= sel_b;
        op_signed <= sel_signed;
        op_id     <= pick_idx;
        ptr       <= pick_idx;
      end
      if (state == ST_EXEC) begin
        rsp_valid_q  <= 1'b1;
        rsp_id_q     <= op_id;
        rsp_result_q <= {{(WIDTH-1){1'b0}}, lt};
      end else if (state == ST_RESP && bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = ready_c;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: doc/slt_share_arbiter.md
Name: slt_share_arbiter

Overview:
- Multi-cycle arbiter that shares one 32-bit subtract-based less-than comparator among NUM_REQ requesters, e.g. ALU, branch unit and a debug/test port.
- Round-robin grant, valid/ready handshake on each request port, one registered response channel tagged with the requester ID.
- Supports signed (overflow-corrected) and unsigned (borrow-based) compare.
- Sits beside the datapath ALU as the single owner of the comparator resource.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- WIDTH, 32, operand width
- ID_W, 2, width of requester ID; must equal ceil(log2(NUM_REQ))

Ports:
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_signed  input  NUM_REQ  1 = signed compare, 0 = unsigned
- req_a  input  NUM_REQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH]
- req_b  input  NUM_REQ*WIDTH  operand b, same packing
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  ID_W  index of requester that owns the response
- rsp_result  output  WIDTH  {WIDTH-1 zeros, lt}
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (async, immediate): state=IDLE; rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, req_ready=0; rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: when any req_valid is high, pick the first valid index searching from pointer+1 with wrap-around. req_ready[g]=1 combinationally in the same cycle. On that edge, latch a, b, signed and g, set pointer=g, go to EXEC. With no valid requests, stay in IDLE with req_ready=0.
  - EXEC: compute diff = a - b as a + ~b + 1 in WIDTH+1 bits.
    - unsigned lt = borrow, i.e. NOT carry-out.
    - signed lt = diff[WIDTH-1] XOR overflow, where overflow = (a[MSB] != b[MSB]) and (diff[MSB] != a[MSB]).
    - Register rsp_result, rsp_id and rsp_valid=1, then go to RESP.
  - RESP: hold rsp_* stable until rsp_ready=1. On the handshake edge, clear rsp_valid and go to IDLE. req_ready=0 throughout.
- Latency: the response is visible the cycle after EXEC, i.e. 2 edges after acceptance. Peak throughput is 1 op per 3 cycles.
- req_ready is 0 in EXEC and RESP. Requesters must hold valid and operands stable until ready. A dropped req_valid before grant is legal and loses no data.
- Simultaneous requests: exactly one grant. Every continuously-requesting port is served within NUM_REQ grants; no starvation.
- rsp_ready high while rsp_valid is low is ignored.
- Reset asserted during EXEC or RESP aborts the operation. No response is emitted after reset release.
- Operands a==b give lt=0 in both modes.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2
  - default WIDTH/NUM_REQ constants
- One sub-module, rr_priority_picker: combinational. Inputs are the request vector and pointer; outputs are the one-hot grant and encoded index.
- Comparator logic stays inline in the top module.

Test Plan:
- Unsigned compare, port 0 only, a=5, b=7 -> rsp_valid 2 edges after accept, rsp_id=0, rsp_result=32'h1. Swapping a and b gives 32'h0.
- Signed overflow case: a=32'h8000_0000, b=32'h0000_0001, signed -> result 1. Same operands unsigned -> result 0. a=32'h7FFF_FFFF, b=32'hFFFF_FFFF, signed -> 0.
- All 4 ports valid continuously after reset, rsp_ready=1 -> grant order 0,1,2,3,0. rsp_id follows that sequence; ops are spaced 3 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id and rsp_result stay constant. All req_ready stay 0 until the handshake, then the next grant occurs in IDLE.
- Reset pulse asserted mid-EXEC -> outputs go to 0 immediately. After release, port 0 is granted first even if port 3 was pending.
- Equal operands 32'hDEAD_BEEF in both modes -> result 0. Single port 2 requesting after port 1 was last granted -> port 2 wins with no idle cycle.
